uart_tx_ahb: RTL and testbench

UART_TX_AHB -- requirements
Module: uart_tx_ahb

---
 rtl/uart_tx_ahb_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_tx_ahb.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_ahb.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ahb_pkg.sv
// Shared definitions for the AHB UART transmitter: register offsets, STATUS bit
// positions (also used by software tests) and the serializer state type.
package uart_tx_ahb_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; shared by the UART TX and RX paths.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_ahb.sv
// AHB-attached UART transmitter: register decode, TX FIFO and 8N1 serializer with
// a programmable per-bit clock divisor.
module uart_tx_ahb
    import uart_tx_ahb_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr_s,
    input  logic [2:0]  hsize_s,
    input  logic        hwrite_s,
    input  logic [31:0] hwdata_s,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        txd
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

    logic             dphase_p1;
    logic             write_p1;
    logic [1:0]       off_p1;
    logic [15:0]      baud_div;
    logic             wr_tx;
    logic             push;
    logic             load;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             busy;
    logic [31:0]      status;
    logic             unused_ok;

    tx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic [15:0] div_act, div_n;
    logic [15:0] div_eff;

    assign unused_ok = ^{haddr_s[31:4], haddr_s[1:0], hsize_s, hwdata_s[31:16]};

    // A TXDATA write into a full FIFO stretches the data phase until a slot frees.
    assign wr_tx  = dphase_p1 && write_p1 && (off_p1 == OFF_TXDATA);
    assign hready = !(wr_tx && fifo_full);
    assign push   = wr_tx && !fifo_full;

    // ---- address phase -> data phase ----
    always_ff @(posedge clk) begin
        if (rst) begin
            dphase_p1 <= 1'b0;
            write_p1  <= 1'b0;
            off_p1    <= OFF_TXDATA;
            baud_div  <= 16'(DEFAULT_DIV);
        end else begin
            if (hready) begin
                dphase_p1 <= hsel;
                if (hsel) begin
                    off_p1   <= haddr_s[3:2];
                    write_p1 <= hwrite_s;
                end
            end
            if (dphase_p1 && write_p1 && (off_p1 == OFF_BAUDDIV))
                baud_div <= hwdata_s[15:0];
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        status                                  = '0;
        status[STAT_BUSY]                       = busy;
        status[STAT_FULL]                       = fifo_full;
        status[STAT_EMPTY]                      = fifo_empty;
        status[STAT_CNT_LSB +: STAT_CNT_W]      = STAT_CNT_W'(fifo_count);
    end

    always_comb begin
        hrdata = '0;
        if (dphase_p1 && !write_p1) begin
            case (off_p1)
                OFF_STATUS:  hrdata = status;
                OFF_BAUDDIV: hrdata = {16'h0000, baud_div};
                default:     hrdata = '0;
            endcase
        end
    end

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (hwdata_s[7:0]),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---- serializer ----
    assign div_eff = eff_div(baud_div);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        shreg_n = shreg;
        div_n   = div_act;
        load    = 1'b0;
        case (state)
            ST_IDLE: load = !fifo_empty;
            ST_START: begin
                if (cnt == 16'd0) begin
                    state_n = ST_DATA;
                    cnt_n   = div_act - 16'd1;
                    idx_n   = 3'd0;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt == 16'd0) begin
                    cnt_n   = div_act - 16'd1;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = ST_STOP;
                    else                 idx_n   = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt == 16'd0) begin
                    if (fifo_empty) state_n = ST_IDLE;
                    else            load    = 1'b1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Divisor is captured at the pop so mid-frame BAUDDIV writes wait for the next frame.
        if (load) begin
            state_n = ST_START;
            cnt_n   = div_eff - 16'd1;
            div_n   = div_eff;
            shreg_n = fifo_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg   <= shreg_n;
        div_act <= div_n;
    end

    always_comb begin
        case (state)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shreg[0];
            default:  txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ahb.sv
// Directed scoreboard bench for uart_tx_ahb: bus reads and serial frames are
// checked by independent monitors against queued expectations.
module tb_uart_tx_ahb;

    localparam int DEPTH   = 8;
    localparam int DEF_DIV = 868;
    localparam logic [31:0] A_TXDATA = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_BAUD   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        hsel     = 1'b0;
    logic [31:0] haddr_s  = '0;
    logic [2:0]  hsize_s  = 3'd2;
    logic        hwrite_s = 1'b0;
    logic [31:0] hwdata_s = '0;
    logic [31:0] hrdata;
    logic        hready;
    logic        txd;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
        int         start;
    } frame_t;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    frame_t  sb_tx[$];
    rd_exp_t sb_rd[$];

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    bit rd_dphase    = 1'b0;
    bit abort        = 1'b0;
    bit frame_active = 1'b0;
    int last_start   = 0;
    int last_end     = -100;

    uart_tx_ahb #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hsel     (hsel),
        .haddr_s  (haddr_s),
        .hsize_s  (hsize_s),
        .hwrite_s (hwrite_s),
        .hwdata_s (hwdata_s),
        .hrdata   (hrdata),
        .hready   (hready),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-data monitor.
    always @(negedge clk) begin
        if (rd_dphase && hready === 1'b1) begin
            if (sb_rd.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                rd_exp_t r;
                r = sb_rd.pop_front();
                check(r.name, hrdata, r.val);
            end
        end
    end

    // Serial-line monitor: decodes one 8N1 frame using the queued divisor.
    task automatic rx_frame();
        frame_t     e;
        logic [7:0] got;
        int         bad;
        int         start;
        start        = cyc;
        bad          = 0;
        got          = '0;
        frame_active = 1'b1;
        last_start   = start;
        if (sb_tx.size() == 0) begin
            check("tx_unexpected_frame", 32'd1, 32'd0);
            frame_active = 1'b0;
            return;
        end
        e = sb_tx.pop_front();
        if (e.start >= 0) check("tx_first_low_cycle", start, e.start);
        if (e.b2b) check("tx_b2b_gap", start - last_end - 1, 0);
        for (int s = 1; s < e.div; s++) begin
            @(negedge clk);
            if (abort) begin frame_active = 1'b0; return; end
            if (txd !== 1'b0) bad++;
        end
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < e.div; s++) begin
                @(negedge clk);
                if (abort) begin frame_active = 1'b0; return; end
                if (s == 0) got[i] = txd;
                else if (txd !== got[i]) bad++;
            end
        end
        for (int s = 0; s < e.div; s++) begin
            @(negedge clk);
            if (abort) begin frame_active = 1'b0; return; end
            if (txd !== 1'b1) bad++;
        end
        last_end     = cyc;
        frame_active = 1'b0;
        check("tx_byte", got, e.data);
        check("tx_bit_timing_errors", bad, 0);
    endtask

    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && !abort) rx_frame();
        end
    end

    task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rd_exp_t r;
        r.name = name;
        r.val  = exp;
        sb_rd.push_back(r);
        @(posedge clk); #1;
        hsel = 1'b1; haddr_s = addr; hwrite_s = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; rd_dphase = 1'b1;
        @(posedge clk); #1;
        rd_dphase = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, input int div,
                             input bit b2b, input bit chk_lat, output int dcyc, output int stall);
        frame_t f;
        @(posedge clk); #1;
        hsel = 1'b1; haddr_s = addr; hwrite_s = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; hwdata_s = data; stall = 0;
        while (hready !== 1'b1 && stall < 2000) begin
            @(posedge clk); #1;
            stall++;
        end
        if (hready !== 1'b1) check("write_stall_timeout", 32'd0, 32'd1);
        dcyc = cyc;
        if (addr == A_TXDATA) begin
            f.data  = data[7:0];
            f.div   = div;
            f.b2b   = b2b;
            f.start = chk_lat ? dcyc + 2 : -1;
            sb_tx.push_back(f);
        end
    endtask

    task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
        int d, s;
        ahb_write(addr, data, 0, 1'b0, 1'b0, d, s);
    endtask

    task automatic send(input logic [7:0] b, input int div, input bit b2b, input bit chk_lat);
        int d, s;
        ahb_write(A_TXDATA, {24'h0, b}, div, b2b, chk_lat, d, s);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((sb_tx.size() != 0 || frame_active || txd !== 1'b1) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_within_budget", (sb_tx.size() == 0 && !frame_active && txd === 1'b1), 1);
    endtask

    initial begin : main
        int         d, st, d0, stall_sum, n, lows;
        logic [7:0] fill_bytes [10];
        fill_bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h33, 8'hCC};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", txd, 1);
        check("reset_hready", hready, 1);
        check("reset_hrdata", hrdata, 0);
        rst = 1'b0;
        ahb_read(A_STATUS, 32'h0000_0004, "status_after_reset");
        ahb_read(A_BAUD, DEF_DIV, "bauddiv_after_reset");
        ahb_read(A_RSVD, 32'h0, "reserved_read");

        // Single frame 0xA5 at 4 cycles/bit, first low at D+2.
        wr_reg(A_BAUD, 32'd4);
        ahb_read(A_BAUD, 32'd4, "bauddiv_readback_4");
        send(8'hA5, 4, 1'b0, 1'b1);
        ahb_read(A_TXDATA, 32'h0, "txdata_read_zero");
        wait_idle(200);
        ahb_read(A_STATUS, 32'h0000_0004, "status_idle_after_frame");

        // First byte goes straight to the serializer, three stay queued.
        send(8'h11, 4, 1'b0, 1'b1);
        send(8'h22, 4, 1'b1, 1'b0);
        send(8'h33, 4, 1'b1, 1'b0);
        send(8'h44, 4, 1'b1, 1'b0);
        ahb_read(A_STATUS, 32'h0000_0031, "status_busy_count3");
        wait_idle(400);

        // Divisor change mid-frame applies to the following frame only.
        send(8'h3C, 4, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        wr_reg(A_BAUD, 32'd8);
        send(8'hC3, 8, 1'b1, 1'b0);
        ahb_read(A_BAUD, 32'h0000_0008, "bauddiv_readback_8");
        wait_idle(400);

        // Divisor 0 behaves as 1: a 10-cycle frame.
        wr_reg(A_BAUD, 32'd0);
        send(8'hFF, 1, 1'b0, 1'b1);
        wait_idle(100);

        // Ten writes: byte 0 leaves the FIFO at once, so the tenth finds it full
        // and completes the cycle after the end of frame 0 frees a slot.
        wr_reg(A_BAUD, 32'd4);
        stall_sum = 0;
        d0 = 0;
        for (int k = 0; k < 10; k++) begin
            ahb_write(A_TXDATA, {24'h0, fill_bytes[k]}, 4, (k != 0), (k == 0), d, st);
            if (k == 0) d0 = d;
            if (k < 9) stall_sum += st;
        end
        check("fill_no_stall_first9", stall_sum, 0);
        check("fill_tenth_stalled", (st > 0), 1);
        check("fill_tenth_release_cycle", d, d0 + 2 + 40);
        wait_idle(1000);

        // Reset during DATA bit 3 of 0x17 (bit 3 is 0, so a surviving frame would show low).
        send(8'h17, 4, 1'b0, 1'b1);
        n = 0;
        while (!frame_active && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_test_frame_started", frame_active, 1);
        n = 0;
        while (cyc < last_start + 17 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b1;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_frame_txd", txd, 1);
        check("rst_mid_frame_hready", hready, 1);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        ahb_read(A_STATUS, 32'h0000_0004, "status_after_mid_rst");
        ahb_read(A_BAUD, DEF_DIV, "bauddiv_after_mid_rst");
        lows = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        check("txd_idle_after_rst", lows, 0);

        check("sb_tx_drained", sb_tx.size(), 0);
        check("sb_rd_drained", sb_rd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
